bus_mux_reg: RTL and testbench

- Parametrised, registered successor to the datapath bus multiplexer.
- Selects one of NUM_SRC source words from a one-hot enable vector and drives a registered bus word with one cycle of latency.
- Adds behaviour the combinational mux lacks:
  - detection of multiple drivers, with an error state machine;
  - selectable lowest-index priority resolution;
  - a stall/hold capability;
  - source-index reporting;
  - a saturating conflict counter.
- Sits between the register file/special registers and the ALU/MDR inputs of the CPU datapath.

---
 rtl/bus_pkg.sv | 16 +
 rtl/onehot_encoder.sv | 24 ++
 rtl/bus_mux_reg.sv | 145 ++++++++++++++
 tb/tb_bus_mux_reg.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and constants for the registered bus multiplexer.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    FAULT = 2'd2
  } bus_state_e;

  localparam int NUM_SRC_DEF = 24;
  localparam int DATA_W_DEF  = 32;

  localparam int PRIORITY_FAULT = 0;
  localparam int PRIORITY_LOW   = 1;

endpackage

// File: rtl/onehot_encoder.sv
// Combinational decode of a source-enable vector: lowest set index, zero and multi-hot flags.
module onehot_encoder #(
  parameter int NUM_SRC = 24,
  parameter int SEL_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] en_i,
  output logic [SEL_W-1:0]   idx_o,
  output logic               zero_o,
  output logic               multi_o
);

  always_comb begin
    idx_o = '0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (en_i[i]) idx_o = SEL_W'(i);
    end
  end

  assign zero_o  = ~|en_i;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_o = |(en_i & (en_i - NUM_SRC'(1)));

endmodule

// File: rtl/bus_mux_reg.sv
// Registered one-hot bus multiplexer with conflict detection, fault FSM, stall and saturating conflict counter.
// Optional macro BUS_MUX_PARITY_EN adds a registered even-parity output bus_parity.
module bus_mux_reg
  import bus_pkg::*;
#(
  parameter int NUM_SRC       = NUM_SRC_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int SEL_W         = $clog2(NUM_SRC),
  parameter int PRIORITY_MODE = PRIORITY_FAULT,
  parameter int CNT_W         = 8
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic [NUM_SRC-1:0]        src_en,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic                      stall,
  input  logic                      err_clr,
  output logic [DATA_W-1:0]         bus_out,
  output logic                      bus_valid,
  output logic [SEL_W-1:0]          bus_src,
  output logic                      conflict,
  output logic                      conflict_sticky,
  output logic [CNT_W-1:0]          conflict_count
`ifdef BUS_MUX_PARITY_EN
  ,
  output logic                      bus_parity
`endif
);

  logic [SEL_W-1:0]  hot_idx;
  logic              hot_zero;
  logic              hot_multi;
  logic [DATA_W-1:0] words [NUM_SRC];
  logic [DATA_W-1:0] sel_word;

  bus_state_e        state_q, state_d;
  logic [DATA_W-1:0] bus_out_q, bus_out_d;
  logic              bus_valid_q, bus_valid_d;
  logic [SEL_W-1:0]  bus_src_q, bus_src_d;
  logic              conflict_q, conflict_d;
  logic              sticky_q, sticky_d;
  logic [CNT_W-1:0]  count_q, count_d;

  onehot_encoder #(
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
  ) u_enc (
    .en_i    (src_en),
    .idx_o   (hot_idx),
    .zero_o  (hot_zero),
    .multi_o (hot_multi)
  );

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_words
    assign words[g] = src_data[g*DATA_W +: DATA_W];
  end

  assign sel_word = words[hot_idx];

  always_comb begin
    state_d     = state_q;
    bus_out_d   = bus_out_q;
    bus_valid_d = bus_valid_q;
    bus_src_d   = bus_src_q;
    conflict_d  = 1'b0;
    sticky_d    = sticky_q;
    count_d     = count_q;

    if (!stall) begin
      case (state_q)
        IDLE, DRIVE: begin
          if (hot_zero) begin
            state_d     = IDLE;
            bus_valid_d = 1'b0;
          end else if (hot_multi && (PRIORITY_MODE == PRIORITY_FAULT)) begin
            state_d     = FAULT;
            bus_valid_d = 1'b0;
          end else begin
            state_d     = DRIVE;
            bus_out_d   = sel_word;
            bus_src_d   = hot_idx;
            bus_valid_d = 1'b1;
          end
        end
        FAULT: begin
          bus_valid_d = 1'b0;
          if (err_clr) state_d = IDLE;
        end
        default: begin
          state_d     = IDLE;
          bus_valid_d = 1'b0;
        end
      endcase

      // A new conflict outranks an acknowledge in the same cycle.
      if (hot_multi) begin
        conflict_d = 1'b1;
        sticky_d   = 1'b1;
        if (count_q != {CNT_W{1'b1}}) count_d = count_q + CNT_W'(1);
      end else if (err_clr) begin
        sticky_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= IDLE;
      bus_out_q   <= '0;
      bus_valid_q <= 1'b0;
      bus_src_q   <= '0;
      conflict_q  <= 1'b0;
      sticky_q    <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      bus_out_q   <= bus_out_d;
      bus_valid_q <= bus_valid_d;
      bus_src_q   <= bus_src_d;
      conflict_q  <= conflict_d;
      sticky_q    <= sticky_d;
      count_q     <= count_d;
    end
  end

  assign bus_out         = bus_out_q;
  assign bus_valid       = bus_valid_q;
  assign bus_src         = bus_src_q;
  assign conflict        = conflict_q;
  assign conflict_sticky = sticky_q;
  assign conflict_count  = count_q;

`ifdef BUS_MUX_PARITY_EN
  logic parity_q;

  // Parity follows whatever word bus_out is about to hold, so it loads and holds with it.
  always_ff @(posedge clk) begin
    if (clr) parity_q <= 1'b0;
    else     parity_q <= ^bus_out_d;
  end

  assign bus_parity = parity_q;
`endif

endmodule

// File: tb/tb_bus_mux_reg.sv
// Directed bench for bus_mux_reg: fault-mode and priority-mode instances share stimulus and are checked against a behavioural model.
module tb_bus_mux_reg;

  localparam int NS = 24;
  localparam int DW = 32;
  localparam int SW = 5;
  localparam int CW = 8;

  logic            clk = 1'b0;
  logic            clr;
  logic [NS-1:0]   src_en;
  logic [NS*DW-1:0] src_data;
  logic            stall;
  logic            err_clr;

  logic [DW-1:0]   bo [2];
  logic            bv [2];
  logic [SW-1:0]   bs [2];
  logic            cf [2];
  logic            st [2];
  logic [CW-1:0]   cc [2];
  logic            bp [2];

  int n_vec  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  bus_mux_reg #(.NUM_SRC(NS), .DATA_W(DW), .SEL_W(SW), .PRIORITY_MODE(0), .CNT_W(CW)) u_fault (
    .clk(clk), .clr(clr), .src_en(src_en), .src_data(src_data), .stall(stall), .err_clr(err_clr),
    .bus_out(bo[0]), .bus_valid(bv[0]), .bus_src(bs[0]), .conflict(cf[0]),
    .conflict_sticky(st[0]), .conflict_count(cc[0])
`ifdef BUS_MUX_PARITY_EN
    , .bus_parity(bp[0])
`endif
  );

  bus_mux_reg #(.NUM_SRC(NS), .DATA_W(DW), .SEL_W(SW), .PRIORITY_MODE(1), .CNT_W(CW)) u_prio (
    .clk(clk), .clr(clr), .src_en(src_en), .src_data(src_data), .stall(stall), .err_clr(err_clr),
    .bus_out(bo[1]), .bus_valid(bv[1]), .bus_src(bs[1]), .conflict(cf[1]),
    .conflict_sticky(st[1]), .conflict_count(cc[1])
`ifdef BUS_MUX_PARITY_EN
    , .bus_parity(bp[1])
`endif
  );

`ifndef BUS_MUX_PARITY_EN
  assign bp[0] = 1'b0;
  assign bp[1] = 1'b0;
`endif

  // Behavioural model, one slot per instance (0 = fault mode, 1 = priority mode).
  logic [DW-1:0] m_out    [2] = '{default: '0};
  logic          m_valid  [2] = '{default: 1'b0};
  int            m_src    [2] = '{default: 0};
  logic          m_conf   [2] = '{default: 1'b0};
  logic          m_sticky [2] = '{default: 1'b0};
  int            m_count  [2] = '{default: 0};
  bit            m_faulted[2] = '{default: 1'b0};

  always @(posedge clk) begin
    int n;
    int low;
    n   = $countones(src_en);
    low = 0;
    for (int i = NS - 1; i >= 0; i--) if (src_en[i]) low = i;
    for (int m = 0; m < 2; m++) begin
      if (clr) begin
        m_out[m] = '0; m_valid[m] = 0; m_src[m] = 0; m_conf[m] = 0;
        m_sticky[m] = 0; m_count[m] = 0; m_faulted[m] = 0;
      end else if (stall) begin
        m_conf[m] = 0;
      end else begin
        m_conf[m] = (n > 1);
        if (n > 1 && m_count[m] < 255) m_count[m] = m_count[m] + 1;
        if (n > 1) m_sticky[m] = 1;
        else if (err_clr) m_sticky[m] = 0;
        if (m_faulted[m]) begin
          m_valid[m] = 0;
          if (err_clr) m_faulted[m] = 0;
        end else if (n == 0) begin
          m_valid[m] = 0;
        end else if (n > 1 && m == 0) begin
          m_faulted[m] = 1;
          m_valid[m]   = 0;
        end else begin
          m_out[m]   = src_data[low*DW +: DW];
          m_src[m]   = low;
          m_valid[m] = 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("m%0d.bus_out", m), 64'(bo[m]), 64'(m_out[m]));
        chk($sformatf("m%0d.bus_valid", m), 64'(bv[m]), 64'(m_valid[m]));
        chk($sformatf("m%0d.bus_src", m), 64'(bs[m]), 64'(m_src[m]));
        chk($sformatf("m%0d.conflict", m), 64'(cf[m]), 64'(m_conf[m]));
        chk($sformatf("m%0d.sticky", m), 64'(st[m]), 64'(m_sticky[m]));
        chk($sformatf("m%0d.count", m), 64'(cc[m]), 64'(m_count[m]));
`ifdef BUS_MUX_PARITY_EN
        chk($sformatf("m%0d.parity", m), 64'(bp[m]), 64'(^m_out[m]));
`endif
      end
    end
  end

  task automatic step(input logic [NS-1:0] en, input logic ec = 1'b0,
                      input logic stl = 1'b0, input logic cl = 1'b0);
    src_en  = en;
    err_clr = ec;
    stall   = stl;
    clr     = cl;
    @(negedge clk);
  endtask

  initial begin
    clr = 1'b1; stall = 1'b0; err_clr = 1'b0; src_en = 24'h000008;
    for (int i = 0; i < NS; i++) src_data[i*DW +: DW] = (32'h01010101 * i) ^ 32'h5A000000;
    src_data[3*DW +: DW]  = 32'hDEADBEEF;
    src_data[5*DW +: DW]  = 32'hCAFE0005;
    src_data[10*DW +: DW] = 32'h00000007;
    src_data[11*DW +: DW] = 32'h00000003;

    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst.bus_out", 64'(bo[0]), 64'h0);
    chk("rst.bus_valid", 64'(bv[0]), 64'h0);
    chk("rst.count", 64'(cc[1]), 64'h0);

    step(24'h000008);
    chk("single.bus_out", 64'(bo[0]), 64'hDEADBEEF);
    chk("single.bus_src", 64'(bs[0]), 64'd3);
    chk("single.bus_valid", 64'(bv[0]), 64'h1);
    step(24'h000000);
    chk("zero.bus_valid", 64'(bv[0]), 64'h0);
    chk("zero.bus_out_hold", 64'(bo[0]), 64'hDEADBEEF);

    step(24'h000011);
    chk("fault.conflict", 64'(cf[0]), 64'h1);
    chk("fault.sticky", 64'(st[0]), 64'h1);
    chk("fault.count", 64'(cc[0]), 64'h1);
    chk("fault.bus_valid", 64'(bv[0]), 64'h0);
    step(24'h000001);
    chk("fault.ignored", 64'(bv[0]), 64'h0);
    chk("fault.pulse_end", 64'(cf[0]), 64'h0);
    step(24'h000000, 1'b1);
    chk("errclr.sticky", 64'(st[0]), 64'h0);
    step(24'h000008);
    chk("recover.bus_valid", 64'(bv[0]), 64'h1);

    step(24'h800020);
    chk("prio.bus_src", 64'(bs[1]), 64'd5);
    chk("prio.bus_out", 64'(bo[1]), 64'hCAFE0005);
    chk("prio.conflict", 64'(cf[1]), 64'h1);
    chk("prio.bus_valid", 64'(bv[1]), 64'h1);
    step(24'h000000, 1'b1);
    step(24'h000008);

    step(24'h000011, 1'b0, 1'b1);
    step(24'h000020, 1'b0, 1'b1);
    step(24'h000000, 1'b1, 1'b1);
    chk("stall.bus_out", 64'(bo[1]), 64'hDEADBEEF);
    chk("stall.bus_valid", 64'(bv[0]), 64'h1);
    chk("stall.conflict", 64'(cf[1]), 64'h0);
    chk("stall.count", 64'(cc[1]), 64'd2);

    step(24'h000004);
    step(24'h000030, 1'b1);
    chk("setwins.sticky", 64'(st[1]), 64'h1);
    step(24'h000004, 1'b1);
    chk("errclr_drive.sticky", 64'(st[1]), 64'h0);
    chk("errclr_drive.valid", 64'(bv[1]), 64'h1);

    step(24'h000011);
    step(24'h000008, 1'b0, 1'b0, 1'b1);
    chk("clr_fault.bus_out", 64'(bo[0]), 64'h0);
    chk("clr_fault.sticky", 64'(st[0]), 64'h0);
    chk("clr_fault.count", 64'(cc[0]), 64'h0);

    step(24'h000400);
    chk("par7.bus_out", 64'(bo[0]), 64'h7);
`ifdef BUS_MUX_PARITY_EN
    chk("par7.parity", 64'(bp[0]), 64'h1);
`endif
    step(24'h000800);
    chk("par3.bus_out", 64'(bo[0]), 64'h3);
`ifdef BUS_MUX_PARITY_EN
    chk("par3.parity", 64'(bp[0]), 64'h0);
`endif

    for (int k = 0; k < 300; k++) step(24'h000003);
    chk("sat.count_fault", 64'(cc[0]), 64'd255);
    chk("sat.count_prio", 64'(cc[1]), 64'd255);
    step(24'h000000);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
